alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 77 +++++++
 tb/tb_alu_exec_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU with bit-serial shifter; in clk,rst(async low),Start,ALUOps[4],A[32],B[32],Shamt[5]; out Result[32],Done,Busy,CarryFlag,ZeroFlag,SignFlag
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [3:0]  ALUOps,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  Shamt,
  output logic [31:0] Result,
  output logic        Done,
  output logic        Busy,
  output logic        CarryFlag,
  output logic        ZeroFlag,
  output logic        SignFlag
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] work, work_nx, res;
  logic [32:0] sum;
  logic [4:0] cnt, amt;
  logic [1:0] styp, typ;
  logic acc, is_sh, is_add, go_sh;
  always_comb begin
    acc = Start && state != SHIFT;
    is_sh = ALUOps inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101};
    amt = (ALUOps[2] || ALUOps == 4'b0011) ? B[4:0] : Shamt;
    typ = ALUOps inside {4'b0000, 4'b0100} ? 2'd0 : ALUOps inside {4'b0001, 4'b0101} ? 2'd1 : 2'd2;
    go_sh = is_sh && amt != 5'd0;
    is_add = ALUOps == 4'b1010;
    sum = {1'b0, A} + {1'b0, B};
    res = is_add ? sum[31:0] :
          ALUOps == 4'b1111 ? 32'd0 - B :
          ALUOps == 4'b1011 ? A - B :
          ALUOps == 4'b1000 ? A & B :
          ALUOps == 4'b1001 ? A ^ B :
          (ALUOps == 4'b1110 || is_sh) ? A : 32'd0;
    work_nx = styp == 2'd0 ? {work[30:0], 1'b0} : {styp == 2'd2 && work[31], work[31:1]};
    state_nx = acc ? (go_sh ? SHIFT : DONE) :
               state == SHIFT ? (cnt == 5'd1 ? DONE : SHIFT) : IDLE;
  end
  assign Done = state == DONE;
  assign Busy = state == SHIFT;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work <= '0;
      cnt <= '0;
      styp <= '0;
      Result <= '0;
      CarryFlag <= 1'b0;
      ZeroFlag <= 1'b0;
      SignFlag <= 1'b0;
    end else if (acc) begin
      if (go_sh) begin
        work <= A;
        cnt <= amt;
        styp <= typ;
      end else begin
        Result <= res;
        ZeroFlag <= res == 32'd0;
        SignFlag <= res[31];
        if (is_add) CarryFlag <= sum[32];
      end
    end else if (state == SHIFT) begin
      work <= work_nx;
      cnt <= cnt - 5'd1;
      if (cnt == 5'd1) begin
        Result <= work_nx;
        ZeroFlag <= work_nx == 32'd0;
        SignFlag <= work_nx[31];
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit
module tb_alu_exec_unit;
  logic clk = 1'b0, rst = 1'b1, Start = 1'b0;
  logic [3:0] ALUOps = '0;
  logic [31:0] A = '0, B = '0;
  logic [4:0] Shamt = '0;
  logic [31:0] Result;
  logic Done, Busy, CarryFlag, ZeroFlag, SignFlag;
  int checks = 0, errors = 0;
  logic [34:0] sb[$];
  localparam logic [3:0] ADD = 4'b1010, COMP = 4'b1111, DIFF = 4'b1011, AND_ = 4'b1000,
    XOR_ = 4'b1001, PASS = 4'b1110, SHLL = 4'b0000, SHRL = 4'b0001, SHRA = 4'b0010,
    SHLLV = 4'b0100, SHRLV = 4'b0101, SHRAV = 4'b0011;
  always #5 clk = ~clk;
  alu_exec_unit dut (
    .clk(clk), .rst(rst), .Start(Start), .ALUOps(ALUOps), .A(A), .B(B), .Shamt(Shamt),
    .Result(Result), .Done(Done), .Busy(Busy), .CarryFlag(CarryFlag), .ZeroFlag(ZeroFlag),
    .SignFlag(SignFlag)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [34:0] e;
    if (rst && Done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: Result %0h with empty scoreboard", Result);
      end else begin
        e = sb.pop_front();
        chk("result_czs", {Result, CarryFlag, ZeroFlag, SignFlag}, e);
      end
    end
  end
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] res, input logic c, input bit push);
    ALUOps = op; A = a; B = b; Shamt = sh; Start = 1'b1;
    if (push) sb.push_back({res, c, res == 32'd0, res[31]});
    @(posedge clk);
    #1 Start = 1'b0;
    A = $urandom; B = $urandom; Shamt = 5'($urandom); ALUOps = 4'($urandom);
  endtask
  task automatic wait_done(output int cyc, output int bn);
    bit got = 0;
    cyc = 0; bn = 0;
    while (!got && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (Done) got = 1;
      else if (Busy) bn++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no Done within %0d cycles", cyc);
    end
  endtask
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh, input logic [31:0] res, input logic c, input int nb);
    int cyc, bn;
    issue(op, a, b, sh, res, c, 1);
    wait_done(cyc, bn);
    chk("busy_cycles", 64'(bn), 64'(nb));
    chk("latency", 64'(cyc), 64'(nb + 1));
    @(negedge clk);
  endtask
  initial begin
    int cyc, bn, b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_result", Result, 0);
    chk("rst_done_busy", {Done, Busy}, 0);
    chk("rst_flags", {CarryFlag, ZeroFlag, SignFlag}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(ADD, 32'hFFFFFFFF, 32'd1, 5'd0, 32'h0, 1'b1, 0);
    run(SHRA, 32'h80000000, 32'h0, 5'd4, 32'hF8000000, 1'b1, 4);
    run(SHLLV, 32'h1234, 32'h20, 5'd7, 32'h1234, 1'b1, 0);
    run(COMP, 32'h9, 32'd5, 5'd0, 32'hFFFFFFFB, 1'b1, 0);
    run(DIFF, 32'd5, 32'd7, 5'd0, 32'hFFFFFFFE, 1'b1, 0);
    run(AND_, 32'hF0F0FF00, 32'h0FF00FF0, 5'd0, 32'h00F00F00, 1'b1, 0);
    run(XOR_, 32'hAAAA5555, 32'hFFFF0000, 5'd0, 32'h55555555, 1'b1, 0);
    run(PASS, 32'h80000001, 32'h3, 5'd0, 32'h80000001, 1'b1, 0);
    run(4'b0110, 32'd5, 32'd5, 5'd0, 32'h0, 1'b1, 0);
    run(4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b1, 0);
    run(ADD, 32'd7, 32'd8, 5'd0, 32'hF, 1'b0, 0);
    run(SHLL, 32'd1, 32'h0, 5'd31, 32'h80000000, 1'b0, 31);
    run(SHRLV, 32'h80000000, 32'h24, 5'd9, 32'h08000000, 1'b0, 4);
    run(SHRAV, 32'hF0000000, 32'd1, 5'd9, 32'hF8000000, 1'b0, 1);
    run(SHRA, 32'h80000000, 32'h5, 5'd0, 32'h80000000, 1'b0, 0);
    run(ADD, 32'h80000000, 32'h80000000, 5'd0, 32'h0, 1'b1, 0);
    issue(SHRL, 32'hFFFFFFFF, 32'h0, 5'd31, 32'h1, 1'b1, 1);
    b0 = 0;
    repeat (4) begin
      @(negedge clk);
      if (Busy) b0++;
    end
    ALUOps = ADD; A = 32'd1; B = 32'd1; Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    wait_done(cyc, bn);
    chk("ignored_start_busy", 64'(b0 + bn), 64'd31);
    @(negedge clk);
    issue(SHLL, 32'd1, 32'h0, 5'd10, 32'h0, 1'b0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_result", Result, 0);
    chk("abort_done_busy", {Done, Busy}, 0);
    chk("abort_flags", {CarryFlag, ZeroFlag, SignFlag}, 0);
    repeat (3) @(negedge clk);
    chk("abort_hold", {Result, Done, Busy}, 0);
    rst = 1'b1;
    @(negedge clk);
    run(COMP, 32'h0, 32'd5, 5'd0, 32'hFFFFFFFB, 1'b0, 0);
    issue(SHLL, 32'd3, 32'h0, 5'd2, 32'hC, 1'b0, 1);
    wait_done(cyc, bn);
    chk("b2b_first_busy", 64'(bn), 64'd2);
    issue(ADD, 32'hFFFFFFFF, 32'd2, 5'd0, 32'h1, 1'b1, 1);
    wait_done(cyc, bn);
    chk("b2b_add_latency", 64'(cyc), 64'd1);
    issue(XOR_, 32'd1, 32'd1, 5'd0, 32'h0, 1'b1, 1);
    wait_done(cyc, bn);
    chk("b2b_xor_latency", 64'(cyc), 64'd1);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
